// File: rtl/drops_pkg.sv
// Shared types and width helpers for the matrix scanner.
package drops_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } scan_state_e;

    // Index width for a counter over n positions; never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/scan_timer.sv
// Row/slot counters for the scanner: cnt walks 0..DWELL-1 inside each row,
// row walks 0..ROWS-1, last_o flags the final slot of the frame.
module scan_timer
    import drops_pkg::*;
#(
    parameter  int ROWS     = 8,
    parameter  int BRIGHT_W = 3,
    localparam int ROW_W    = idx_width(ROWS)
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                run_i,
    output logic [ROW_W-1:0]    row_o,
    output logic [BRIGHT_W-1:0] cnt_o,
    output logic                last_o
);

    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROWS - 1);

    // NOTE: non-blocking assignments so cnt and row both update from pre-edge values.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            row_o <= '0;
            cnt_o <= '0;
        end else if (!run_i) begin
            row_o <= '0;
            cnt_o <= '0;
        end else begin
            // DWELL is a power of two, so cnt wraps on its own.
            cnt_o <= cnt_o + 1'b1;
            if (cnt_o == '1) begin
                row_o <= (row_o == ROW_LAST) ? '0 : row_o + 1'b1;
            end
        end
    end

    assign last_o = (row_o == ROW_LAST) && (cnt_o == '1);

endmodule

// File: rtl/matrix_scan.sv
// LED matrix row scanner: double-buffered frame image, per-row PWM brightness,
// registered row/column drivers with a blanking slot at the end of every row.
module matrix_scan
    import drops_pkg::*;
#(
    parameter int ROWS        = 8,
    parameter int COLS        = 8,
    parameter int BRIGHT_W    = 3,
    parameter int COL_ACT_LOW = 0
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [ROWS*COLS-1:0] matrix_i,
    input  logic                 load_i,
    output logic                 load_ack_o,
    input  logic [BRIGHT_W-1:0]  bright_i,
    input  logic                 en_i,
    output logic [ROWS-1:0]      row_val_o,
    output logic [COLS-1:0]      col_val_o,
    output logic                 frame_o,
    output logic                 busy_o
);

    localparam int              ROW_W   = idx_width(ROWS);
    localparam logic [COLS-1:0] COL_INV = (COL_ACT_LOW != 0) ? {COLS{1'b1}} : {COLS{1'b0}};
    localparam logic [ROWS-1:0] ROW_ONE = {{(ROWS-1){1'b0}}, 1'b1};

    scan_state_e          state;
    logic                 scanning;
    logic [ROW_W-1:0]     row;
    logic [BRIGHT_W-1:0]  cnt;
    logic                 last;
    logic [ROWS*COLS-1:0] shadow;
    logic [ROWS*COLS-1:0] active;
    logic                 pending;
    logic [BRIGHT_W-1:0]  bright_lat;
    logic [BRIGHT_W-1:0]  bright_eff;
    logic [COLS-1:0]      row_cols;
    logic                 lit;
    logic                 xfer;

    assign scanning = (state == SCAN);

    scan_timer #(
        .ROWS     (ROWS),
        .BRIGHT_W (BRIGHT_W)
    ) u_timer (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .run_i  (scanning),
        .row_o  (row),
        .cnt_o  (cnt),
        .last_o (last)
    );

    // NOTE: every signal here is assigned on every path, so no latch is inferred.
    always_comb begin
        // Slot 0 uses the live brightness; later slots use the value caught at slot 0.
        bright_eff = (cnt == '0) ? bright_i : bright_lat;
        row_cols   = active[int'(row)*COLS +: COLS];
        lit        = scanning && (cnt < bright_eff) && (cnt != '1);
        xfer       = !scanning || last;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state      <= IDLE;
            bright_lat <= '0;
            row_val_o  <= '0;
            col_val_o  <= COL_INV;
            load_ack_o <= 1'b0;
        end else begin
            case (state)
                IDLE:    if (en_i) state <= SCAN;
                SCAN:    if (last && !en_i) state <= IDLE;
                default: state <= IDLE;
            endcase
            if (cnt == '0) begin
                bright_lat <= bright_i;
            end
            row_val_o  <= scanning ? (ROW_ONE << row) : '0;
            col_val_o  <= (lit ? row_cols : '0) ^ COL_INV;
            load_ack_o <= load_i;
        end
    end

    // NOTE: the image buffers are reset so a mid-frame reset discards any captured frame.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            shadow  <= '0;
            active  <= '0;
            pending <= 1'b0;
        end else begin
            if (load_i) begin
                shadow <= matrix_i;
            end
            // A capture on the transfer cycle itself bypasses the shadow copy.
            if (xfer) begin
                if (load_i) begin
                    active <= matrix_i;
                end else if (pending) begin
                    active <= shadow;
                end
                pending <= 1'b0;
            end else if (load_i) begin
                pending <= 1'b1;
            end
        end
    end

    assign frame_o = scanning && last;
    assign busy_o  = scanning;

endmodule

// File: tb/tb_matrix_scan.sv
// Bench for matrix_scan: default build against a frame-position model,
// plus a small active-low build checked with directed arithmetic.
module tb_matrix_scan;

    localparam int A_ROWS = 8;
    localparam int A_COLS = 8;
    localparam int A_DW   = 8;
    localparam int A_FR   = A_ROWS * A_DW;

    logic clk;
    int   n_pass  = 0;
    int   n_total = 0;
    int   cyc     = 0;

    // Default-parameter instance
    logic        rst_a;
    logic [63:0] mat_a;
    logic        load_a, en_a;
    logic [2:0]  bright_a;
    logic        ack_a, frame_a, busy_a;
    logic [7:0]  row_a, col_a;

    // Small active-low instance
    logic        rst_b;
    logic [23:0] mat_b;
    logic        load_b, en_b;
    logic [1:0]  bright_b;
    logic        ack_b, frame_b, busy_b;
    logic [3:0]  row_b;
    logic [5:0]  col_b;

    matrix_scan u_dut_a (
        .clk_i      (clk),
        .rst_i      (rst_a),
        .matrix_i   (mat_a),
        .load_i     (load_a),
        .load_ack_o (ack_a),
        .bright_i   (bright_a),
        .en_i       (en_a),
        .row_val_o  (row_a),
        .col_val_o  (col_a),
        .frame_o    (frame_a),
        .busy_o     (busy_a)
    );

    matrix_scan #(
        .ROWS        (4),
        .COLS        (6),
        .BRIGHT_W    (2),
        .COL_ACT_LOW (1)
    ) u_dut_b (
        .clk_i      (clk),
        .rst_i      (rst_b),
        .matrix_i   (mat_b),
        .load_i     (load_b),
        .load_ack_o (ack_b),
        .bright_i   (bright_b),
        .en_i       (en_b),
        .row_val_o  (row_b),
        .col_val_o  (col_b),
        .frame_o    (frame_b),
        .busy_o     (busy_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: position in frame as a single cycle index m_t.
    bit          m_scan;
    int          m_t;
    logic [63:0] m_active, m_shadow;
    bit          m_pending;
    int          m_blat;
    logic [18:0] exp_vec;
    logic [18:0] act_vec;

    assign act_vec = {ack_a, row_a, col_a, frame_a, busy_a};

    task automatic model_reset();
        m_scan    = 0;
        m_t       = 0;
        m_active  = '0;
        m_shadow  = '0;
        m_pending = 0;
        m_blat    = 0;
    endtask

    // Predict the outputs after the coming edge, advance the model, then clock.
    task automatic step_a();
        int          row, slot, eff;
        bit          boundary;
        logic [7:0]  e_row, e_col;
        logic        e_ack;
        row   = m_t / A_DW;
        slot  = m_t % A_DW;
        eff   = (slot == 0) ? int'(bright_a) : m_blat;
        e_row = m_scan ? 8'(1 << row) : 8'h00;
        e_col = (m_scan && slot < eff && slot < A_DW - 1) ? m_active[row*A_COLS +: A_COLS] : 8'h00;
        e_ack = load_a;
        boundary = m_scan && (m_t == A_FR - 1);
        if (!m_scan || boundary) begin
            if (load_a) m_active = mat_a;
            else if (m_pending) m_active = m_shadow;
            m_pending = 0;
        end else if (load_a) begin
            m_pending = 1;
        end
        if (load_a) m_shadow = mat_a;
        if (slot == 0) m_blat = int'(bright_a);
        if (!m_scan || boundary) begin
            m_scan = en_a;
            m_t    = 0;
        end else begin
            m_t++;
        end
        exp_vec = {e_ack, e_row, e_col, (m_scan && m_t == A_FR - 1), m_scan};
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic test_reset();
        rst_a = 1; rst_b = 1;
        mat_a = '0; load_a = 0; en_a = 0; bright_a = '0;
        mat_b = '0; load_b = 0; en_b = 0; bright_b = '0;
        model_reset();
        #2;
        n_total++;
        if (act_vec !== 19'h0) $display("FAIL reset_a: got %h want %h", act_vec, 19'h0);
        else n_pass++;
        n_total++;
        if ({ack_b, row_b, col_b, frame_b, busy_b} !== {1'b0, 4'h0, 6'h3F, 1'b0, 1'b0})
            $display("FAIL reset_b: got row=%h col=%h busy=%b", row_b, col_b, busy_b);
        else n_pass++;
        @(negedge clk);
        rst_a = 0;
    endtask

    task automatic test_diagonal();
        int last_frame = -1;
        int frames = 0;
        mat_a = 64'h8040201008040201;
        load_a = 1; bright_a = 3'd7; en_a = 1;
        for (int i = 0; i < 140; i++) begin
            step_a();
            load_a = 0;
            n_total++;
            if (act_vec !== exp_vec) $display("FAIL diagonal c%0d: got %h want %h", cyc, act_vec, exp_vec);
            else n_pass++;
            if (frame_a) begin
                if (last_frame >= 0) begin
                    n_total++;
                    if (cyc - last_frame != A_FR) $display("FAIL frame_period: got %0d want %0d", cyc - last_frame, A_FR);
                    else n_pass++;
                end
                last_frame = cyc;
                frames++;
            end
        end
        n_total++;
        if (frames != 2) $display("FAIL frame_count: got %0d want 2", frames);
        else n_pass++;
    endtask

    task automatic test_brightness();
        int lit0, lit1;
        for (int i = 0; i < 200 && !(m_scan && m_t == 0); i++) begin
            step_a();
            n_total++;
            if (act_vec !== exp_vec) $display("FAIL bright_align c%0d: got %h want %h", cyc, act_vec, exp_vec);
            else n_pass++;
        end
        bright_a = 3'd0;
        for (int i = 0; i < A_FR; i++) begin
            step_a();
            n_total++;
            if (col_a !== 8'h00 || row_a === 8'h00 || act_vec !== exp_vec)
                $display("FAIL bright_zero c%0d: got row=%h col=%h want scanning row, col=00", cyc, row_a, col_a);
            else n_pass++;
        end
        lit0 = 0; lit1 = 0;
        bright_a = 3'd2;
        for (int i = 0; i < 2 * A_DW; i++) begin
            if (i == 4) bright_a = 3'd5;
            step_a();
            n_total++;
            if (act_vec !== exp_vec) $display("FAIL bright_change c%0d: got %h want %h", cyc, act_vec, exp_vec);
            else n_pass++;
            if (col_a !== 8'h00) begin
                if (i < A_DW) lit0++;
                else lit1++;
            end
        end
        n_total++;
        if (lit0 != 2 || lit1 != 5) $display("FAIL bright_lat: got lit %0d,%0d want 2,5", lit0, lit1);
        else n_pass++;
    endtask

    task automatic test_load_timing();
        logic [63:0] img;
        img = {$urandom, $urandom};
        for (int i = 0; i < 200 && !(m_scan && m_t == 3 * A_DW + 2); i++) begin
            step_a();
            n_total++;
            if (act_vec !== exp_vec) $display("FAIL load_align c%0d: got %h want %h", cyc, act_vec, exp_vec);
            else n_pass++;
        end
        mat_a = img; load_a = 1;
        step_a();
        load_a = 0;
        n_total++;
        if (ack_a !== 1'b1 || act_vec !== exp_vec) $display("FAIL load_ack: got ack=%b want 1", ack_a);
        else n_pass++;
        for (int i = 0; i < A_FR; i++) begin
            step_a();
            n_total++;
            if (act_vec !== exp_vec) $display("FAIL load_tear c%0d: got %h want %h", cyc, act_vec, exp_vec);
            else n_pass++;
        end
    endtask

    task automatic test_boundary_load();
        logic [63:0] img, img1, img2;
        int acks;
        img  = {$urandom, $urandom};
        img1 = {$urandom, $urandom};
        img2 = {$urandom, $urandom};
        for (int i = 0; i < 200 && !(m_scan && m_t == A_FR - 1); i++) begin
            step_a();
            n_total++;
            if (act_vec !== exp_vec) $display("FAIL bnd_align c%0d: got %h want %h", cyc, act_vec, exp_vec);
            else n_pass++;
        end
        mat_a = img; load_a = 1;
        step_a();
        load_a = 0;
        n_total++;
        if (ack_a !== 1'b1 || act_vec !== exp_vec) $display("FAIL bnd_ack: got ack=%b want 1", ack_a);
        else n_pass++;
        step_a();
        n_total++;
        if (col_a !== img[7:0] || row_a !== 8'h01) $display("FAIL bnd_show: got row=%h col=%h want 01/%h", row_a, col_a, img[7:0]);
        else n_pass++;
        acks = 0;
        for (int i = 1; i < A_FR; i++) begin
            load_a = (i == 8 || i == 40);
            mat_a  = (i < 20) ? img1 : img2;
            step_a();
            n_total++;
            if (act_vec !== exp_vec) $display("FAIL two_loads c%0d: got %h want %h", cyc, act_vec, exp_vec);
            else n_pass++;
            if (ack_a) acks++;
        end
        load_a = 0;
        n_total++;
        if (acks != 2) $display("FAIL two_acks: got %0d want 2", acks);
        else n_pass++;
        step_a();
        n_total++;
        if (col_a !== img2[7:0] || row_a !== 8'h01) $display("FAIL two_show: got row=%h col=%h want 01/%h", row_a, col_a, img2[7:0]);
        else n_pass++;
    endtask

    task automatic test_disable();
        int  steps = 0;
        bit  saw_frame = 0;
        for (int i = 0; i < 200 && !(m_scan && m_t == 2 * A_DW); i++) begin
            step_a();
            n_total++;
            if (act_vec !== exp_vec) $display("FAIL dis_align c%0d: got %h want %h", cyc, act_vec, exp_vec);
            else n_pass++;
        end
        en_a = 0;
        for (int i = 0; i < 100 && busy_a; i++) begin
            step_a();
            steps++;
            n_total++;
            if (act_vec !== exp_vec) $display("FAIL disable c%0d: got %h want %h", cyc, act_vec, exp_vec);
            else n_pass++;
            if (frame_a) saw_frame = 1;
        end
        n_total++;
        if (busy_a !== 1'b0 || steps != A_FR - 2 * A_DW || !saw_frame)
            $display("FAIL dis_finish: got busy=%b steps=%0d frame=%b want 0/%0d/1", busy_a, steps, saw_frame, A_FR - 2 * A_DW);
        else n_pass++;
        step_a();
        n_total++;
        if (row_a !== 8'h00 || col_a !== 8'h00 || busy_a !== 1'b0)
            $display("FAIL dis_idle: got row=%h col=%h busy=%b want 00/00/0", row_a, col_a, busy_a);
        else n_pass++;
    endtask

    task automatic test_random();
        en_a = 1;
        for (int i = 0; i < 600; i++) begin
            load_a = ($urandom_range(0, 7) == 0);
            if (load_a) mat_a = {$urandom, $urandom};
            if ($urandom_range(0, 3) == 0) bright_a = 3'($urandom);
            if ($urandom_range(0, 99) == 0) en_a = ~en_a;
            step_a();
            n_total++;
            if (act_vec !== exp_vec) $display("FAIL random c%0d: got %h want %h", cyc, act_vec, exp_vec);
            else n_pass++;
        end
        load_a = 0;
    endtask

    task automatic test_small_config();
        int          r, s, last_frame;
        logic [5:0]  rb, e_col;
        logic [3:0]  e_row;
        @(negedge clk);
        rst_b = 0;
        mat_b = 24'($urandom);
        bright_b = 2'd3; load_b = 1; en_b = 1;
        last_frame = -1;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            #1;
            load_b = 0;
            if (k == 1) begin
                e_row = 4'h0;
                e_col = 6'h3F;
            end else begin
                r = ((k - 2) / 4) % 4;
                s = (k - 2) % 4;
                rb = mat_b[r*6 +: 6];
                e_row = 4'(1 << r);
                e_col = (s < 3) ? ~rb : 6'h3F;
            end
            n_total++;
            if ({ack_b, row_b, col_b, frame_b, busy_b} !== {(k == 1), e_row, e_col, ((k - 1) % 16 == 15), 1'b1})
                $display("FAIL small k%0d: got ack=%b row=%h col=%h frame=%b busy=%b want %b/%h/%h/%b/1",
                         k, ack_b, row_b, col_b, frame_b, busy_b, (k == 1), e_row, e_col, ((k - 1) % 16 == 15));
            else n_pass++;
            if (frame_b) begin
                if (last_frame >= 0) begin
                    n_total++;
                    if (k - last_frame != 16) $display("FAIL small_period: got %0d want 16", k - last_frame);
                    else n_pass++;
                end
                last_frame = k;
            end
        end
        // Capture an image that stays pending, then reset mid-row between edges.
        mat_b = 24'hFFFFFF; load_b = 1;
        @(posedge clk);
        #1;
        load_b = 0;
        #2;
        n_total++;
        if (busy_b !== 1'b1 || row_b === 4'h0) $display("FAIL small_prereset: got busy=%b row=%h", busy_b, row_b);
        else n_pass++;
        rst_b = 1;
        #1;
        n_total++;
        if ({ack_b, row_b, col_b, frame_b, busy_b} !== {1'b0, 4'h0, 6'h3F, 1'b0, 1'b0})
            $display("FAIL async_rst: got ack=%b row=%h col=%h frame=%b busy=%b", ack_b, row_b, col_b, frame_b, busy_b);
        else n_pass++;
        @(negedge clk);
        rst_b = 0;
        for (int k = 1; k <= 14; k++) begin
            @(posedge clk);
            #1;
            n_total++;
            if (col_b !== 6'h3F || frame_b !== 1'b0 || (k >= 2 && row_b !== 4'(1 << ((k - 2) / 4))))
                $display("FAIL discard k%0d: got row=%h col=%h frame=%b want col=3f frame=0", k, row_b, col_b, frame_b);
            else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_diagonal();
        test_brightness();
        test_load_timing();
        test_boundary_load();
        test_disable();
        test_random();
        test_small_config();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
